// File: rtl/mode_shift_reg_if.sv
// Control/data bundle for mode_shift_reg. The dir signal exists only when
// MODE_SHIFT_REG_DIR_EN is defined.
interface mode_shift_reg_if #(
    parameter int OUT_W = 8,
    parameter int WIN_W = 4,
    parameter int CNT_W = 7
);
    logic             en;
    logic [1:0]       mode;
    logic             d;
    logic [WIN_W-1:0] win_sel;
`ifdef MODE_SHIFT_REG_DIR_EN
    logic             dir;
`endif
    logic [OUT_W-1:0] out;
    logic             serial_out;
    logic [CNT_W-1:0] fill_cnt;
    logic             full;

`ifdef MODE_SHIFT_REG_DIR_EN
    modport master (output en, mode, d, win_sel, dir,
                    input  out, serial_out, fill_cnt, full);
    modport slave  (input  en, mode, d, win_sel, dir,
                    output out, serial_out, fill_cnt, full);
`else
    modport master (output en, mode, d, win_sel,
                    input  out, serial_out, fill_cnt, full);
    modport slave  (input  en, mode, d, win_sel,
                    output out, serial_out, fill_cnt, full);
`endif
endinterface

// File: rtl/mode_shift_reg.sv
// Multi-mode DEPTH-bit shift register (hold/shift-in/rotate/clear) with a saturating
// fill counter and a registered OUT_W-bit window. MODE_SHIFT_REG_DIR_EN adds a dir input.
module mode_shift_reg #(
    parameter int DEPTH = 96,
    parameter int OUT_W = 8,
    parameter int WIN_W = 4,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    mode_shift_reg_if.slave bus
);
    localparam int NUM_WIN = DEPTH / OUT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_ROT   = 2'b10,
        MODE_CLR   = 2'b11
    } mode_e;

    mode_e            mode_w;
    logic             dir_w;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] win_w [NUM_WIN];

    assign mode_w = mode_e'(bus.mode);

`ifdef MODE_SHIFT_REG_DIR_EN
    assign dir_w = bus.dir;
`else
    assign dir_w = 1'b0;
`endif

    always_comb begin
        sr_d       = sr_q;
        fill_cnt_d = fill_cnt_q;
        if (bus.en) begin
            case (mode_w)
                MODE_SHIFT: begin
                    sr_d = dir_w ? {bus.d, sr_q[DEPTH-1:1]} : {sr_q[DEPTH-2:0], bus.d};
                    if (fill_cnt_q < CNT_MAX)
                        fill_cnt_d = fill_cnt_q + CNT_W'(1);
                end
                MODE_ROT:
                    sr_d = dir_w ? {sr_q[0], sr_q[DEPTH-1:1]} : {sr_q[DEPTH-2:0], sr_q[DEPTH-1]};
                MODE_CLR: begin
                    sr_d       = '0;
                    fill_cnt_d = '0;
                end
                default: begin
                    sr_d       = sr_q;
                    fill_cnt_d = fill_cnt_q;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
        assign win_w[gi] = sr_q[gi*OUT_W +: OUT_W];
    end

    // Out-of-range window indices fall through to zero.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (bus.win_sel == WIN_W'(i))
                out_d = win_w[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q       <= '0;
            fill_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            sr_q       <= sr_d;
            fill_cnt_q <= fill_cnt_d;
            out_q      <= out_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.serial_out = dir_w ? sr_q[0] : sr_q[DEPTH-1];
    assign bus.fill_cnt   = fill_cnt_q;
    assign bus.full       = (fill_cnt_q == CNT_MAX);
endmodule

// File: tb/tb_mode_shift_reg.sv
// Bench for mode_shift_reg: hand-derived vector table plus a scoreboard fed by a
// behavioural model, with directed corner sequences and a random phase.
`timescale 1ns/100ps
module tb_mode_shift_reg;
    localparam int DEPTH = 96;
    localparam int OUT_W = 8;
    localparam int WIN_W = 4;
    localparam int CNT_W = 7;

    typedef struct {
        logic [7:0] out;
        logic [6:0] cnt;
        logic       full;
        logic       ser;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       d;
        logic [3:0] win;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [95:0] m_sr = '0;
    int   m_cnt = 0;
    vec_t tab[9];
    exp_t none_e = '{8'h00, 7'h00, 1'b0, 1'b0};
`ifdef MODE_SHIFT_REG_DIR_EN
    logic dir_v = 1'b0;
`endif

    mode_shift_reg_if #(.OUT_W(OUT_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

    mode_shift_reg #(.DEPTH(DEPTH), .OUT_W(OUT_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle, push the expected post-edge outputs, then pop and compare.
    task automatic cycle(input logic en_v, input logic [1:0] mode_v, input logic d_v,
                         input logic [3:0] win_v, input bit use_tab, input exp_t tab_e,
                         input string tag);
        exp_t e;
        exp_t got;
        logic dir_m;
        dir_m = 1'b0;
        @(negedge clk);
        bus.en = en_v; bus.mode = mode_v; bus.d = d_v; bus.win_sel = win_v;
`ifdef MODE_SHIFT_REG_DIR_EN
        bus.dir = dir_v;
        dir_m = dir_v;
`endif
        e.out = (win_v < 12) ? m_sr[win_v*8 +: 8] : 8'h00;
        if (en_v) begin
            case (mode_v)
                2'b01: begin
                    m_sr = dir_m ? {d_v, m_sr[95:1]} : {m_sr[94:0], d_v};
                    if (m_cnt < 96) m_cnt++;
                end
                2'b10: m_sr = dir_m ? {m_sr[0], m_sr[95:1]} : {m_sr[94:0], m_sr[95]};
                2'b11: begin m_sr = '0; m_cnt = 0; end
                default: ;
            endcase
        end
        e.cnt  = 7'(m_cnt);
        e.full = (m_cnt == 96);
        e.ser  = dir_m ? m_sr[0] : m_sr[95];
        sb_q.push_back(use_tab ? tab_e : e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({tag, ".out"},  32'(bus.out),        32'(got.out));
            check({tag, ".cnt"},  32'(bus.fill_cnt),   32'(got.cnt));
            check({tag, ".full"}, 32'(bus.full),       32'(got.full));
            check({tag, ".ser"},  32'(bus.serial_out), 32'(got.ser));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out"},  32'(bus.out),        32'd0);
        check({tag, ".cnt"},  32'(bus.fill_cnt),   32'd0);
        check({tag, ".full"}, 32'(bus.full),       32'd0);
        check({tag, ".ser"},  32'(bus.serial_out), 32'd0);
    endtask

    initial begin
        // Shift 1,0,1,1,0,0,1,0 then hold; out shows the low byte before each edge.
        tab[0] = '{1'b1, 2'b01, 1'b1, 4'd0, '{8'h00, 7'd1, 1'b0, 1'b0}};
        tab[1] = '{1'b1, 2'b01, 1'b0, 4'd0, '{8'h01, 7'd2, 1'b0, 1'b0}};
        tab[2] = '{1'b1, 2'b01, 1'b1, 4'd0, '{8'h02, 7'd3, 1'b0, 1'b0}};
        tab[3] = '{1'b1, 2'b01, 1'b1, 4'd0, '{8'h05, 7'd4, 1'b0, 1'b0}};
        tab[4] = '{1'b1, 2'b01, 1'b0, 4'd0, '{8'h0B, 7'd5, 1'b0, 1'b0}};
        tab[5] = '{1'b1, 2'b01, 1'b0, 4'd0, '{8'h16, 7'd6, 1'b0, 1'b0}};
        tab[6] = '{1'b1, 2'b01, 1'b1, 4'd0, '{8'h2C, 7'd7, 1'b0, 1'b0}};
        tab[7] = '{1'b1, 2'b01, 1'b0, 4'd0, '{8'h59, 7'd8, 1'b0, 1'b0}};
        tab[8] = '{1'b1, 2'b00, 1'b0, 4'd0, '{8'hB2, 7'd8, 1'b0, 1'b0}};

        bus.en = 1'b0; bus.mode = 2'b00; bus.d = 1'b0; bus.win_sel = '0;
`ifdef MODE_SHIFT_REG_DIR_EN
        bus.dir = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            cycle(tab[i].en, tab[i].mode, tab[i].d, tab[i].win, 1'b1, tab[i].e, $sformatf("tab%0d", i));

        // Asynchronous reset between edges, mid-operation.
        #2 reset = 1'b1;
        #1 check_zero("reset_async");
        bus.en = 1'b0; bus.mode = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        m_sr = '0; m_cnt = 0;

        // Saturating fill with all ones, window 11 at the top.
        cycle(1'b1, 2'b11, 1'b0, 4'd11, 1'b0, none_e, "clr_a");
        for (int i = 0; i < 101; i++) cycle(1'b1, 2'b01, 1'b1, 4'd11, 1'b0, none_e, "fill");
        cycle(1'b1, 2'b00, 1'b0, 4'd11, 1'b0, none_e, "fill_hold");
        check("sat.out",  32'(bus.out),        32'hFF);
        check("sat.cnt",  32'(bus.fill_cnt),   32'd96);
        check("sat.full", 32'(bus.full),       32'd1);
        check("sat.ser",  32'(bus.serial_out), 32'd1);

        // Walk a single 1 to the top, rotate it back to bit 0.
        cycle(1'b1, 2'b11, 1'b0, 4'd0, 1'b0, none_e, "clr_b");
        cycle(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, none_e, "one");
        for (int i = 0; i < 95; i++) cycle(1'b1, 2'b01, 1'b0, 4'd0, 1'b0, none_e, "zeros");
        cycle(1'b1, 2'b10, 1'b0, 4'd0, 1'b0, none_e, "rot");
        cycle(1'b1, 2'b00, 1'b0, 4'd0, 1'b0, none_e, "rot_hold");
        check("rot.out",  32'(bus.out),      32'h01);
        check("rot.cnt",  32'(bus.fill_cnt), 32'd96);
        check("rot.full", 32'(bus.full),     32'd1);

        // Clear gated by en, then an out-of-range window.
        cycle(1'b0, 2'b11, 1'b0, 4'd0, 1'b0, none_e, "clr_en0");
        check("clr_en0.cnt", 32'(bus.fill_cnt), 32'd96);
        cycle(1'b1, 2'b11, 1'b0, 4'd0, 1'b0, none_e, "clr_en1");
        check("clr_en1.cnt",  32'(bus.fill_cnt), 32'd0);
        check("clr_en1.full", 32'(bus.full),     32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, none_e, "ones8");
        cycle(1'b1, 2'b00, 1'b0, 4'd12, 1'b0, none_e, "win12");
        check("win12.out", 32'(bus.out), 32'h00);
        cycle(1'b1, 2'b00, 1'b0, 4'd0, 1'b0, none_e, "win0");
        check("win0.out", 32'(bus.out), 32'hFF);

        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'b0, none_e, "rand");

`ifdef MODE_SHIFT_REG_DIR_EN
        dir_v = 1'b1;
        cycle(1'b1, 2'b11, 1'b0, 4'd11, 1'b0, none_e, "dir_clr");
        cycle(1'b1, 2'b01, 1'b1, 4'd11, 1'b0, none_e, "dir_one");
        check("dir_one.ser", 32'(bus.serial_out), 32'd0);
        for (int i = 0; i < 95; i++) cycle(1'b1, 2'b01, 1'b0, 4'd0, 1'b0, none_e, "dir_zeros");
        check("dir_end.ser", 32'(bus.serial_out), 32'd1);
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'b0, none_e, "dir_rand");
        dir_v = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
